// File: rtl/neopix_pkg.sv
// Shared types and default timing for the WS2812 chain driver.
// Defaults assume a 16 MHz clock: 20-cycle bit (1.25 us), 300 us latch.
package neopix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_LATCH
  } state_t;

  // One pixel as it goes on the wire: green first, blue last.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  localparam int DEF_N_PIX    = 8;
  localparam int DEF_T_BIT    = 20;
  localparam int DEF_T0H      = 6;
  localparam int DEF_T1H      = 12;
  localparam int DEF_T_LATCH  = 4800;
  localparam int BITS_PER_PIX = 24;

  // (c * (bright + 1)) >> 8: bright = 255 is identity, bright = 0 blanks.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic pixel_t scale_px(input pixel_t p, input logic [7:0] bright);
    pixel_t q;
    q.g = scale_chan(p.g, bright);
    q.r = scale_chan(p.r, bright);
    q.b = scale_chan(p.b, bright);
    return q;
  endfunction

endpackage

// File: rtl/neopix_bit_enc.sv
// Single-bit WS2812 waveform generator.
// A strobe starts a T_BIT-cycle symbol: high for T1H ('1') or T0H ('0') cycles,
// low for the rest. bit_done marks the last cycle so the next strobe can land
// back-to-back with no gap. The output is registered to keep the pin glitch-free.
module neopix_bit_enc #(
  parameter int T_BIT = 20,
  parameter int T0H   = 6,
  parameter int T1H   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int CW = $clog2(T_BIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI_ONE   = CW'(T1H);
  localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hi_len;
  logic          cur_bit;
  logic          active;

  assign cnt_inc  = cnt + CW'(1);
  assign hi_len   = cur_bit ? HI_ONE : HI_ZERO;
  assign bit_done = active && (cnt == LAST_CNT);

  // Symbol counter and registered line level; strobe wins over bit_done.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cur_bit <= 1'b0;
      active  <= 1'b0;
      dout    <= 1'b0;
    end else if (strobe) begin
      cnt     <= '0;
      cur_bit <= bit_val;
      active  <= 1'b1;
      dout    <= 1'b1;
    end else if (active) begin
      if (cnt == LAST_CNT) begin
        active <= 1'b0;
        dout   <= 1'b0;
      end else begin
        cnt  <= cnt_inc;
        dout <= (cnt_inc < hi_len);
      end
    end
  end

endmodule

// File: rtl/neopix_chain.sv
// WS2812 chain driver: N_PIX-deep GRB buffer streamed MSB-first on START,
// followed by a T_LATCH low period. DONE is asserted in the final latch cycle,
// which is also the first cycle BUSY reads low.
// Optional feature macro: NEOPIX_BRIGHTNESS_EN adds the BRIGHT port and a
// per-frame global brightness scale applied as each pixel is loaded.
module neopix_chain
  import neopix_pkg::*;
#(
  parameter int N_PIX   = DEF_N_PIX,
  parameter int AW      = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  parameter int T_BIT   = DEF_T_BIT,
  parameter int T0H     = DEF_T0H,
  parameter int T1H     = DEF_T1H,
  parameter int T_LATCH = DEF_T_LATCH
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [23:0]   WR_DATA,
  input  logic          START,
`ifdef NEOPIX_BRIGHTNESS_EN
  input  logic [7:0]    BRIGHT,
`endif
  output logic          BUSY,
  output logic          DONE,
  output logic          DOUT
);

  localparam int LW = $clog2(T_LATCH + 1);
  localparam logic [AW-1:0] LAST_PIX   = AW'(N_PIX - 1);
  localparam logic [LW-1:0] LAST_LATCH = LW'(T_LATCH - 1);
  localparam logic [4:0]    MSB_IDX    = 5'(BITS_PER_PIX - 1);

  state_t        state, state_nx;
  pixel_t        buf_mem [N_PIX];
  pixel_t        sreg, nxt_px, rd_px, rd_scaled;
  logic [4:0]    bit_cnt;
  logic [AW-1:0] pix_cnt, pix_next, rd_addr;
  logic [LW-1:0] latch_cnt;
  logic          enc_strobe, enc_bit, bit_done;
  logic          pix_end, last_bit, wr_ok;

  assign wr_ok    = WR_EN && !BUSY && ({1'b0, WR_ADDR} < (AW + 1)'(N_PIX));
  assign pix_next = (pix_cnt == LAST_PIX) ? pix_cnt : pix_cnt + AW'(1);
  assign rd_addr  = (state == ST_LOAD) ? '0 : pix_next;
  assign rd_px    = buf_mem[rd_addr];
  assign pix_end  = bit_done && (bit_cnt == '0);
  assign last_bit = pix_end && (pix_cnt == LAST_PIX);

`ifdef NEOPIX_BRIGHTNESS_EN
  logic [7:0] bright_q;

  // Brightness is captured with START and held for the whole frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bright_q <= 8'hFF;
    end else if (state == ST_IDLE && START) begin
      bright_q <= BRIGHT;
    end
  end

  assign rd_scaled = scale_px(rd_px, bright_q);
`else
  assign rd_scaled = rd_px;
`endif

  // Pixel buffer write port; blocked while a frame is being sent.
  // NOTE: the buffer has no reset on purpose; contents survive RST and it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      buf_mem[WR_ADDR] <= pixel_t'(WR_DATA);
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, status outputs and encoder handshake.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    enc_strobe = 1'b0;
    enc_bit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        BUSY       = 1'b1;
        enc_strobe = 1'b1;
        enc_bit    = rd_scaled[23];
        state_nx   = ST_SEND;
      end
      ST_SEND: begin
        BUSY = 1'b1;
        if (bit_done && !last_bit) begin
          enc_strobe = 1'b1;
          enc_bit    = (bit_cnt == '0) ? nxt_px[23] : sreg[22];
        end
        if (last_bit) state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        if (latch_cnt == LAST_LATCH) begin
          DONE     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          BUSY = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift register, pixel prefetch and bit/pixel/latch counters (all saturating).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sreg      <= '0;
      nxt_px    <= '0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      latch_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          sreg    <= rd_scaled;
          bit_cnt <= MSB_IDX;
          pix_cnt <= '0;
        end
        ST_SEND: begin
          nxt_px <= rd_scaled;
          if (last_bit) begin
            latch_cnt <= '0;
          end else if (pix_end) begin
            sreg    <= nxt_px;
            bit_cnt <= MSB_IDX;
            pix_cnt <= pix_next;
          end else if (bit_done) begin
            sreg    <= pixel_t'({sreg[22:0], 1'b0});
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        ST_LATCH: begin
          if (latch_cnt != LAST_LATCH) latch_cnt <= latch_cnt + LW'(1);
        end
        default: ;
      endcase
    end
  end

  neopix_bit_enc #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_enc (
    .clk      (CLK),
    .rst      (RST),
    .strobe   (enc_strobe),
    .bit_val  (enc_bit),
    .dout     (DOUT),
    .bit_done (bit_done)
  );

endmodule

// File: tb/tb_neopix_chain.sv
// Scoreboard bench for neopix_chain: each START pushes the expected bit stream
// and BUSY length; a DOUT decoder pops and compares as symbols appear on the wire.
module tb_neopix_chain;

  localparam int N_PIX   = 3;
  localparam int AW      = 2;
  localparam int T_BIT   = 20;
  localparam int T0H     = 6;
  localparam int T1H     = 12;
  localparam int T_LATCH = 200;
  localparam int FRAME   = N_PIX * 24 * T_BIT + T_LATCH;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_EN = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [23:0]   WR_DATA = '0;
  logic          START = 1'b0;
  logic          BUSY, DONE, DOUT;
`ifdef NEOPIX_BRIGHTNESS_EN
  logic [7:0]    BRIGHT = 8'hFF;
  int            cur_bright = 255;
`endif

  neopix_chain #(
    .N_PIX(N_PIX), .AW(AW), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_LATCH(T_LATCH)
  ) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START),
`ifdef NEOPIX_BRIGHTNESS_EN
    .BRIGHT(BRIGHT),
`endif
    .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer contents as the host believes them to be.
  logic [23:0] model [N_PIX];
  bit          exp_bits[$];
  int          exp_len[$];
  bit          frame_active = 1'b0;

  function automatic int model_chan(input int c, input int br);
    return (c * (br + 1)) / 256;
  endfunction

  function automatic logic [23:0] model_px(input logic [23:0] p);
`ifdef NEOPIX_BRIGHTNESS_EN
    logic [23:0] q;
    q[23:16] = 8'(model_chan(int'(p[23:16]), cur_bright));
    q[15:8]  = 8'(model_chan(int'(p[15:8]), cur_bright));
    q[7:0]   = 8'(model_chan(int'(p[7:0]), cur_bright));
    return q;
`else
    return p;
`endif
  endfunction

  task automatic push_frame();
    logic [23:0] px;
    for (int p = 0; p < N_PIX; p++) begin
      px = model_px(model[p]);
      for (int b = 23; b >= 0; b--) exp_bits.push_back(px[b]);
    end
    exp_len.push_back(FRAME);
  endtask

  task automatic write_px(input int addr, input logic [23:0] data);
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = AW'(addr); WR_DATA = data;
    if (!frame_active && addr < N_PIX) model[addr] = data;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic start_frame(input bit with_wr, input int addr, input logic [23:0] data);
    @(negedge CLK);
    if (with_wr) begin
      WR_EN = 1'b1; WR_ADDR = AW'(addr); WR_DATA = data;
      if (addr < N_PIX) model[addr] = data;
    end
`ifdef NEOPIX_BRIGHTNESS_EN
    BRIGHT = 8'(cur_bright);
`endif
    push_frame();
    START = 1'b1;
    frame_active = 1'b1;
    @(negedge CLK);
    START = 1'b0; WR_EN = 1'b0;
`ifdef NEOPIX_BRIGHTNESS_EN
    BRIGHT = 8'($urandom_range(0, 255));
`endif
    check("load_busy", BUSY, 1);
    check("load_dout", DOUT, 0);
    @(negedge CLK);
    check("first_rise", DOUT, 1);
  endtask

  // Returns inside the DONE cycle (just after the falling clock edge).
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < FRAME + 50 && !seen; i++) begin
      @(negedge CLK);
      #1;
      if (DONE) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    frame_active = 1'b0;
  endtask

  // DOUT decoder / frame monitor.
  logic prev_d = 1'b0, prev_done = 1'b0;
  bit   have_rise = 1'b0, last_e = 1'b0, e;
  int   hi_len = 0, since_rise = 0, low_run = 0, busy_cnt = 0;

  always @(negedge CLK) begin
    if (RST) begin
      prev_d = 1'b0; prev_done = 1'b0; have_rise = 1'b0;
      hi_len = 0; since_rise = 0; low_run = 0; busy_cnt = 0;
    end else begin
      if (DOUT) begin
        if (!prev_d) begin
          if (have_rise) check("bit_period", since_rise, T_BIT);
          have_rise = 1'b1; since_rise = 0; hi_len = 0;
        end
        hi_len++;
        low_run = 0;
      end else begin
        if (prev_d) begin
          check("bit_expected", int'(exp_bits.size() > 0), 1);
          if (exp_bits.size() > 0) begin
            e = exp_bits.pop_front();
            last_e = e;
            check("bit_high", hi_len, e ? T1H : T0H);
          end
        end
        low_run++;
      end
      since_rise++;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        check("done_busy_low", BUSY, 0);
        check("done_single", prev_done, 0);
        check("bits_left", exp_bits.size(), 0);
        check("latch_low", low_run, T_BIT - (last_e ? T1H : T0H) + T_LATCH);
        check("frame_expected", int'(exp_len.size() > 0), 1);
        if (exp_len.size() > 0) check("busy_len", busy_cnt, exp_len.pop_front());
        busy_cnt = 0;
        have_rise = 1'b0;
      end
      prev_d = DOUT;
      prev_done = DONE;
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_dout", DOUT, 0);
    RST = 1'b0;

    // Known pattern: 8 ones, zeros, a trailing one at the end of pixel 1.
    write_px(0, 24'hFF0000);
    write_px(1, 24'h000001);
    write_px(2, 24'hA5C30F);
    start_frame(1'b0, 0, '0);
    wait_done();

    // START presented in the DONE cycle must be ignored.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    #1;
    check("start_in_done", BUSY, 0);

    // Random frames, each with an out-of-range write that must be dropped.
    repeat (4) begin
      for (int p = 0; p < N_PIX; p++) write_px(p, 24'($urandom));
      write_px(N_PIX, 24'($urandom));
`ifdef NEOPIX_BRIGHTNESS_EN
      cur_bright = $urandom_range(0, 255);
`endif
      start_frame(1'b0, 0, '0);
      wait_done();
    end

    // START and writes during BUSY: no restart, buffer untouched.
    start_frame(1'b0, 0, '0);
    repeat (100) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    write_px(0, 24'($urandom));
    write_px(2, 24'($urandom));
    wait_done();
    @(negedge CLK);
    start_frame(1'b0, 0, '0);
    wait_done();

    // Write and START in the same idle cycle: the new data goes out.
    @(negedge CLK);
    start_frame(1'b1, 1, 24'($urandom));
    wait_done();
    @(negedge CLK);
    start_frame(1'b1, 0, 24'($urandom));
    wait_done();

    // Reset during bit 10 of pixel 0, then a full frame from pixel 0.
    @(negedge CLK);
    start_frame(1'b0, 0, '0);
    repeat (10 * T_BIT + 2) @(negedge CLK);
    @(posedge CLK);
    #3;
    check("bits_before_rst", exp_bits.size(), 24 * N_PIX - 10);
    RST = 1'b1;
    #1;
    check("midrst_dout", DOUT, 0);
    check("midrst_busy", BUSY, 0);
    exp_bits.delete();
    exp_len.delete();
    frame_active = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    start_frame(1'b0, 0, '0);
    wait_done();

`ifdef NEOPIX_BRIGHTNESS_EN
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < N_PIX; p++) write_px(p, 24'h808080);
      cur_bright = (i == 0) ? 127 : (i == 1) ? 255 : 0;
      start_frame(1'b0, 0, '0);
      wait_done();
    end
`endif

    repeat (5) @(negedge CLK);
    check("final_bits_left", exp_bits.size(), 0);
    check("final_busy", BUSY, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
